// File: rtl/downlink_frame_player.sv
// Plays a software-loaded table of downlink user-data words onto the lpGBT downlink,
// one word per clk40 cycle, once or looped, with sticky config and link error flags.
module downlink_frame_player #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
  input  logic                  clk40_i,
  input  logic                  rst40_i,
  input  logic                  cfg_wr_en_i,
  input  logic [DEPTH_LOG2-1:0] cfg_wr_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_wr_data_i,
  input  logic [DEPTH_LOG2:0]   cfg_len_i,
  input  logic                  cfg_loop_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  downlinkrdy_i,
  output logic [DATA_WIDTH-1:0] downlinkUserData_o,
  output logic                  downlinkValid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           passes_o,
  output logic                  cfg_err_o,
  output logic                  link_err_o
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [LW-1:0]         len_q;
  logic                  loop_q;
  logic                  feed;
  // [0]: word sits in the RAM read register, [1]: word is on the link output
  logic [1:0]            vld_pipe;
  logic [1:0]            last_pipe;

  logic busy, len_ok, start_req, accept, kill, pass_end, issue, issue_last;

  always_comb begin
    busy       = (state != IDLE);
    len_ok     = (cfg_len_i != '0) && (cfg_len_i <= LW'(DEPTH));
    start_req  = start_i && !abort_i && !busy;
    accept     = start_req && len_ok && downlinkrdy_i;
    kill       = busy && (abort_i || !downlinkrdy_i);
    pass_end   = vld_pipe[1] && last_pipe[1];
    issue      = (state == PRIME) || ((state == RUN) && feed);
    issue_last = ({1'b0, rd_addr} == (len_q - 1'b1));
  end

  always_ff @(posedge clk40_i) begin
    if (rst40_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PRIME;
      PRIME:   state_nxt = RUN;
      RUN:     if (pass_end && !loop_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Table RAM: writes only land while idle; read register is the first pipeline stage.
  always_ff @(posedge clk40_i) begin
    if (cfg_wr_en_i && !busy) mem[cfg_wr_addr_i] <= cfg_wr_data_i;
    ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk40_i) begin
    if (rst40_i) begin
      rd_addr            <= '0;
      len_q              <= '0;
      loop_q             <= 1'b0;
      feed               <= 1'b0;
      vld_pipe           <= '0;
      last_pipe          <= '0;
      downlinkUserData_o <= IDLE_WORD;
      done_o             <= 1'b0;
      passes_o           <= '0;
      cfg_err_o          <= 1'b0;
      link_err_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;

      if (accept) begin
        len_q      <= cfg_len_i;
        loop_q     <= cfg_loop_i;
        rd_addr    <= '0;
        feed       <= 1'b1;
        cfg_err_o  <= 1'b0;
        link_err_o <= 1'b0;
      end else if (start_req) begin
        if (!len_ok)        cfg_err_o  <= 1'b1;
        if (!downlinkrdy_i) link_err_o <= 1'b1;
      end

      if (busy && cfg_wr_en_i) cfg_err_o <= 1'b1;

      if (issue) begin
        rd_addr <= issue_last ? '0 : rd_addr + 1'b1;
        if (issue_last && !loop_q) feed <= 1'b0;
      end

      vld_pipe           <= {vld_pipe[0], issue};
      last_pipe          <= {last_pipe[0], issue && issue_last};
      downlinkUserData_o <= vld_pipe[0] ? ram_q : IDLE_WORD;

      // A pass whose last word already went out counts, even if killed this cycle.
      if (pass_end && (passes_o != '1)) passes_o <= passes_o + 1'b1;

      if (kill) begin
        feed               <= 1'b0;
        vld_pipe           <= '0;
        last_pipe          <= '0;
        downlinkUserData_o <= IDLE_WORD;
        if (!downlinkrdy_i) link_err_o <= 1'b1;
      end else if (pass_end && !loop_q) begin
        feed               <= 1'b0;
        vld_pipe           <= '0;
        last_pipe          <= '0;
        downlinkUserData_o <= IDLE_WORD;
        done_o             <= 1'b1;
      end
    end
  end

  assign downlinkValid_o = vld_pipe[1];
  assign busy_o          = busy;

endmodule
